// File: rtl/fcn_job_scheduler.sv
// Two-requester round-robin job scheduler in front of a single FCN engine.
// Accepts one image at a time, holds fcn_start for the whole job, and returns
// the engine result (or a timeout marker) tagged with the requester index.
// After each response it waits for fcn_done to fall so that a stale done
// cannot complete the following job.
module fcn_job_scheduler #(
  parameter int unsigned IMG_WIDTH      = 784,
  parameter int unsigned RESULT_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [IMG_WIDTH-1:0]    req0_image,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [IMG_WIDTH-1:0]    req1_image,
  output logic [IMG_WIDTH-1:0]    fcn_image,
  output logic                    fcn_start,
  input  logic [RESULT_WIDTH-1:0] fcn_result,
  input  logic                    fcn_done,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [RESULT_WIDTH-1:0] rsp_result,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    job_count
);

  localparam int unsigned       TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RESP,
    ST_DRAIN
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             req_any;
  logic [TMR_W-1:0] timer;

  // Round-robin pick: the requester that did not win last time gets priority
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req_any    = req0_valid | req1_valid;
  assign req0_ready = (state == ST_IDLE) && req0_valid && !grant;
  assign req1_ready = (state == ST_IDLE) && req1_valid && grant;
  assign busy       = (state != ST_IDLE);

  // Job sequencing: accept, run with timeout, respond, then drain a held done
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      timer       <= '0;
      fcn_image   <= '0;
      fcn_start   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
      job_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            fcn_image  <= grant ? req1_image : req0_image;
            rsp_id     <= grant;
            last_grant <= grant;
            timer      <= '0;
            fcn_start  <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          timer <= timer + 1'b1;
          if (fcn_done) begin
            rsp_result  <= fcn_result;
            rsp_timeout <= 1'b0;
            fcn_start   <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (timer == TMR_LAST) begin
            rsp_result  <= '0;
            rsp_timeout <= 1'b1;
            fcn_start   <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            job_count <= job_count + 1'b1;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!fcn_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcn_job_scheduler.sv
// Bench for fcn_job_scheduler: an FCN engine model reacting to fcn_start,
// a transaction-level scheduler model predicting every output each cycle,
// a table of directed jobs, a mid-job reset, and a randomized phase.
module tb_fcn_job_scheduler;

  localparam int IMG = 784;
  localparam int RW  = 32;
  localparam int TMO = 8;
  localparam int CW  = 16;

  logic            ACLK;
  logic            ARESETN;
  logic            req0_valid, req0_ready;
  logic [IMG-1:0]  req0_image;
  logic            req1_valid, req1_ready;
  logic [IMG-1:0]  req1_image;
  logic [IMG-1:0]  fcn_image;
  logic            fcn_start;
  logic [RW-1:0]   fcn_result;
  logic            fcn_done;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_timeout, busy;
  logic [RW-1:0]   rsp_result;
  logic [CW-1:0]   job_count;

  fcn_job_scheduler #(
    .IMG_WIDTH(IMG), .RESULT_WIDTH(RW), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_image(req0_image),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_image(req1_image),
    .fcn_image(fcn_image), .fcn_start(fcn_start), .fcn_result(fcn_result),
    .fcn_done(fcn_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .busy(busy), .job_count(job_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scheduler contract model: free / job outstanding / waiting for done low
  typedef enum logic [1:0] {P_FREE, P_ACTIVE, P_DRAIN} phase_t;
  phase_t         ph = P_FREE;
  bit             m_last = 1'b1;
  bit             m_rsp_up, m_id, m_to;
  int             m_due;
  logic [RW-1:0]  m_res;
  logic [CW-1:0]  m_cnt = '0;
  logic [IMG-1:0] m_img = '0;
  bit             acc_evt, hs_evt;

  // Knobs for the next accepted job, and the FCN engine model state
  int            next_d = 5, next_h = 0;
  logic [RW-1:0] next_r = '0;
  int            job_d = 1000, job_h = 0, scnt = 0, hold_left = 0;
  logic [RW-1:0] job_r = '0;

  function automatic logic [IMG-1:0] rand_img();
    logic [IMG-1:0] v;
    v = '0;
    for (int i = 0; i < 25; i++) v = {v[IMG-33:0], $urandom()};
    return v;
  endfunction

  task automatic step();
    bit rst_pre, v0, v1, rdy_pre, done_pre, g, e0, e1, acc;
    logic [IMG-1:0] img_pre;
    #1;
    rst_pre = ARESETN; v0 = req0_valid; v1 = req1_valid;
    rdy_pre = rsp_ready; done_pre = fcn_done;
    g = (v0 && v1) ? !m_last : v1;
    e0 = (ph == P_FREE) && v0 && !g;
    e1 = (ph == P_FREE) && v1 && g;
    img_pre = g ? req1_image : req0_image;
    if (rst_pre) begin
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
    end
    acc = rst_pre && (e0 || e1);
    @(posedge ACLK);
    #1;
    cyc++;
    acc_evt = 1'b0;
    hs_evt  = 1'b0;
    if (!rst_pre) begin
      ph = P_FREE; m_last = 1'b1; m_cnt = '0; m_img = '0; m_rsp_up = 1'b0;
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
    end else begin
      case (ph)
        P_FREE: if (acc) begin
          ph = P_ACTIVE; m_id = g; m_last = g; m_img = img_pre; m_rsp_up = 1'b0;
          m_due = cyc + ((next_d < TMO) ? next_d : TMO);
          m_to  = (next_d > TMO);
          m_res = m_to ? '0 : next_r;
          job_d = next_d; job_h = next_h; job_r = next_r; hold_left = 0;
          acc_evt = 1'b1;
        end
        P_ACTIVE: begin
          if (!m_rsp_up) begin
            if (cyc == m_due) m_rsp_up = 1'b1;
          end else if (rdy_pre) begin
            m_cnt++; ph = P_DRAIN; hs_evt = 1'b1;
          end
        end
        P_DRAIN: if (!done_pre) ph = P_FREE;
        default: ph = P_FREE;
      endcase
    end
    chk("busy", busy, ph != P_FREE);
    chk("fcn_start", fcn_start, (ph == P_ACTIVE) && !m_rsp_up);
    chk("rsp_valid", rsp_valid, (ph == P_ACTIVE) && m_rsp_up);
    chk("job_count", job_count, m_cnt);
    total++;
    if (fcn_image !== m_img) begin
      bad++;
      $display("FAIL fcn_image: got ..%08h want ..%08h (cycle %0d)", fcn_image[31:0], m_img[31:0], cyc);
    end
    if ((ph == P_ACTIVE) && m_rsp_up) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_timeout", rsp_timeout, m_to);
      chk("rsp_result", rsp_result, m_res);
    end
    // FCN engine: done after job_d start cycles, then held job_h cycles past start
    if (fcn_start === 1'b1) begin
      scnt++;
      if (scnt >= job_d) begin fcn_done = 1'b1; hold_left = job_h; end
      else fcn_done = 1'b0;
    end else begin
      scnt = 0;
      if (hold_left > 0) begin fcn_done = 1'b1; hold_left--; end
      else fcn_done = 1'b0;
    end
    fcn_result = job_r;
  endtask

  typedef struct {
    bit v0, v1;
    int d, h, bp;
    logic [RW-1:0] r;
    bit e_id, e_to;
    logic [RW-1:0] e_res;
    int e_cnt;
  } row_t;
  row_t rows[9];

  task automatic wait_accept(input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      step();
      if (acc_evt) got = 1'b1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL %s: no accept within bound (cycle %0d)", nm, cyc); end
  endtask

  initial begin
    rows[0] = '{v0:1, v1:0, d:5, h:0, bp:0,  r:32'd7,         e_id:0, e_to:0, e_res:32'd7,         e_cnt:1};
    rows[1] = '{v0:1, v1:1, d:3, h:0, bp:1,  r:32'd3,         e_id:1, e_to:0, e_res:32'd3,         e_cnt:2};
    rows[2] = '{v0:1, v1:1, d:4, h:0, bp:0,  r:32'd9,         e_id:0, e_to:0, e_res:32'd9,         e_cnt:3};
    rows[3] = '{v0:1, v1:1, d:2, h:0, bp:2,  r:32'd3,         e_id:1, e_to:0, e_res:32'd3,         e_cnt:4};
    rows[4] = '{v0:1, v1:1, d:6, h:0, bp:10, r:32'd9,         e_id:0, e_to:0, e_res:32'd9,         e_cnt:5};
    rows[5] = '{v0:0, v1:1, d:9, h:0, bp:0,  r:32'd5,         e_id:1, e_to:1, e_res:32'd0,         e_cnt:6};
    rows[6] = '{v0:1, v1:0, d:8, h:3, bp:0,  r:32'hdeadbeef,  e_id:0, e_to:0, e_res:32'hdeadbeef,  e_cnt:7};
    rows[7] = '{v0:0, v1:1, d:5, h:0, bp:0,  r:32'd11,        e_id:1, e_to:0, e_res:32'd11,        e_cnt:8};
    rows[8] = '{v0:1, v1:0, d:1, h:0, bp:1,  r:32'd42,        e_id:0, e_to:0, e_res:32'd42,        e_cnt:9};

    ARESETN = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_image = '0; req1_image = '0; fcn_done = 1'b0; fcn_result = '0;
    repeat (3) step();
    ARESETN = 1'b1;
    step();

    // Directed jobs from the table
    for (int i = 0; i < 9; i++) begin
      next_d = rows[i].d; next_h = rows[i].h; next_r = rows[i].r;
      if (rows[i].v0 && !req0_valid) begin
        req0_image = (i == 0) ? IMG'(1) : rand_img();
        req0_valid = 1'b1;
      end
      if (!rows[i].v0) req0_valid = 1'b0;
      if (rows[i].v1 && !req1_valid) begin
        req1_image = rand_img();
        req1_valid = 1'b1;
      end
      if (!rows[i].v1) req1_valid = 1'b0;
      rsp_ready = 1'b0;
      wait_accept("row_accept");
      if (m_id) req1_valid = 1'b0; else req0_valid = 1'b0;
      for (int k = 0; k < 40 && rsp_valid !== 1'b1; k++) step();
      chk("row_rsp_valid", rsp_valid, 1);
      chk("row_rsp_id", rsp_id, rows[i].e_id);
      chk("row_rsp_timeout", rsp_timeout, rows[i].e_to);
      chk("row_rsp_result", rsp_result, rows[i].e_res);
      repeat (rows[i].bp) step();
      rsp_ready = 1'b1;
      for (int k = 0; k < 5 && !hs_evt; k++) step();
      rsp_ready = 1'b0;
      chk("row_job_count", job_count, rows[i].e_cnt);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) step();

    // Reset in the middle of a running job
    next_d = 50; next_h = 0; next_r = 32'h55;
    req1_image = rand_img(); req1_valid = 1'b1;
    wait_accept("rst_accept");
    req1_valid = 1'b0;
    repeat (3) step();
    ARESETN = 1'b0;
    step();
    ARESETN = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_fcn_start", fcn_start, 0);
    chk("midrst_job_count", job_count, 0);
    next_d = 2; next_r = 32'h77;
    req0_image = rand_img(); req0_valid = 1'b1;
    req1_image = rand_img(); req1_valid = 1'b1;
    #1;
    chk("midrst_grant0", req0_ready, 1);
    wait_accept("post_rst_accept");
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 30 && ph != P_FREE; k++) step();

    // Randomized traffic, withdrawals and backpressure
    for (int n = 0; n < 500; n++) begin
      next_d = $urandom_range(1, 11);
      next_h = $urandom_range(0, 3);
      next_r = $urandom();
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (!req0_valid) begin
        if ($urandom_range(0, 3) == 0) begin req0_image = rand_img(); req0_valid = 1'b1; end
      end else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
      if (!req1_valid) begin
        if ($urandom_range(0, 3) == 0) begin req1_image = rand_img(); req1_valid = 1'b1; end
      end else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
      step();
      if (acc_evt) begin
        if (m_id) req1_valid = 1'b0; else req0_valid = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 60 && ph != P_FREE; k++) step();
    total++;
    if (ph != P_FREE) begin bad++; $display("FAIL final_drain: scheduler still occupied (cycle %0d)", cyc); end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
